// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: drains a 1-cycle-latency FIFO into a valid/ready stream via a skid buffer.
// Optional statistics ports (rd_count, max_occ) are enabled by defining FIFO_READ_STATS_EN.
module fifo_read_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  rd_err
`ifdef FIFO_READ_STATS_EN
  ,
  output logic [15:0]                     rd_count,
  output logic [$clog2(SKID_DEPTH+1)-1:0] max_occ
`endif
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam logic [PW-1:0] LAST_C  = PW'(SKID_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(SKID_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q;
  logic                    busy_q;
  logic                    rd_err_q;
  logic                    inflight_q;
  logic [CW-1:0]           occ_q;
  logic [PW-1:0]           head_q;
  logic [PW-1:0]           tail_q;
  logic [FIFO_WIDTH-1:0]   mem_q [SKID_DEPTH];

  logic                    push;
  logic                    pop;
  logic [CW:0]             budget;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign push    = inflight_q;
  assign m_valid = (occ_q != '0);
  assign m_data  = mem_q[head_q];
  assign pop     = m_valid & m_ready;
  assign busy    = busy_q;
  assign rd_err  = rd_err_q;

  // Occupancy after this cycle's pop, counting the word already on its way back from the FIFO.
  assign budget     = ({1'b0, occ_q} + {{CW{1'b0}}, inflight_q}) - {{CW{1'b0}}, pop};
  assign fifo_rd_en = (state_q == RUN) && !fifo_empty && (budget < DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) state_q <= DRAIN;
        end
        DRAIN: begin
          if (en) begin
            state_q <= RUN;
          end else if (occ_q == '0 && !inflight_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (push) begin
        mem_q[tail_q] <= fifo_dout;
        tail_q        <= ptr_next(tail_q);
      end
      if (pop) head_q <= ptr_next(head_q);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rd_err_q <= 1'b0;
    else if (fifo_underflow) rd_err_q <= 1'b1;
  end

`ifdef FIFO_READ_STATS_EN
  logic [15:0]   rd_count_q;
  logic [CW-1:0] max_occ_q;

  assign rd_count = rd_count_q;
  assign max_occ  = max_occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      max_occ_q  <= '0;
    end else begin
      if (pop && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      if (occ_q > max_occ_q) max_occ_q <= occ_q;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl: a queue-based FIFO model with 1-cycle read latency feeds the DUT.
// Stats checks are compiled in only when FIFO_READ_STATS_EN is defined.
module tb_fifo_read_ctrl;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          m_ready = 1'b0;
  logic          uf_force = 1'b0;
  logic          uf_model = 1'b0;
  logic          fifo_underflow;
  logic [W-1:0]  fifo_dout = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          busy;
  logic          rd_err;
`ifdef FIFO_READ_STATS_EN
  logic [15:0]   rd_count;
  logic [1:0]    max_occ;
`endif

  fifo_read_ctrl #(.FIFO_WIDTH(W), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .rd_err(rd_err)
`ifdef FIFO_READ_STATS_EN
    , .rd_count(rd_count), .max_occ(max_occ)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_underflow = uf_force | uf_model;

  logic [W-1:0] fq [$];
  logic [W-1:0] rx [$];
  logic [W-1:0] model_w;
  int total = 0, bad = 0, cyc = 0;
  int rd_cnt, rd_first, rd_last, v_cnt, v_first, v_last, empty_rd, uf_cnt;

  // FIFO model: word appears on fifo_dout the cycle after a granted read.
  always @(posedge clk) begin
    cyc++;
    uf_model <= fifo_rd_en & fifo_empty;
    if (fifo_rd_en && !fifo_empty) begin
      model_w = fq.pop_front();
      fifo_dout  <= model_w;
      fifo_empty <= (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_rd_en) begin
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        rd_cnt++;
        if (fifo_empty) empty_rd++;
      end
      if (uf_model) uf_cnt++;
      if (m_valid && m_ready) begin
        if (v_cnt == 0) v_first = cyc;
        v_last = cyc;
        v_cnt++;
        rx.push_back(m_data);
        $display("rx word %h at cycle %0d", m_data, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; rd_first = 0; rd_last = 0;
    v_cnt = 0; v_first = 0; v_last = 0;
    empty_rd = 0; uf_cnt = 0;
    rx.delete();
  endtask

  task automatic load(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + W'(i));
    if (n > 0) fifo_empty = 1'b0;
  endtask

  task automatic flush_fifo();
    fq.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      step(1);
      k++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    clear_mon();
    step(2);
    chk("reset m_valid", {31'd0, m_valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset rd_err", {31'd0, rd_err}, 32'd0);
    chk("reset m_data", {16'd0, m_data}, 32'd0);
    chk("reset rd_en", {31'd0, fifo_rd_en}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // 1: four words, consumer always ready
    clear_mon();
    load(4, 16'h0001);
    m_ready = 1'b1;
    en = 1'b1;
    step(8);
    en = 1'b0;
    wait_idle("t1 idle");
    step(2);
    chk("t1 rd count", rd_cnt, 32'd4);
    chk("t1 rd span", rd_last - rd_first, 32'd3);
    chk("t1 latency", v_first - rd_first, 32'd2);
    chk("t1 pop count", v_cnt, 32'd4);
    chk("t1 pop span", v_last - v_first, 32'd3);
    for (int i = 0; i < 4; i++) chk($sformatf("t1 word%0d", i), {16'd0, rx[i]}, 32'(i + 1));
    chk("t1 m_valid end", {31'd0, m_valid}, 32'd0);

    // 2: eight words, stalled consumer then release
    clear_mon();
    load(8, 16'h0010);
    m_ready = 1'b0;
    en = 1'b1;
    step(6);
    chk("t2 stalled reads", rd_cnt, 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("t2 hold valid", {31'd0, m_valid}, 32'd1);
      chk("t2 hold data", {16'd0, m_data}, 32'h10);
      step(1);
    end
    m_ready = 1'b1;
    step(12);
    chk("t2 pop count", v_cnt, 32'd8);
    chk("t2 no gaps", v_last - v_first, 32'd7);
    for (int i = 0; i < 8; i++) chk($sformatf("t2 word%0d", i), {16'd0, rx[i]}, 32'h10 + 32'(i));
    en = 1'b0;
    wait_idle("t2 idle");
    flush_fifo();

    // 3: en dropped one cycle after the first read
    clear_mon();
    load(8, 16'h0020);
    m_ready = 1'b1;
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(1);
    chk("t3 drain busy", {31'd0, busy}, 32'd1);
    chk("t3 drain no read", {31'd0, fifo_rd_en}, 32'd0);
    wait_idle("t3 idle");
    step(2);
    chk("t3 rd count", rd_cnt, 32'd2);
    chk("t3 fifo left", fq.size(), 32'd6);
    chk("t3 pop count", v_cnt, 32'd2);
    chk("t3 word0", {16'd0, rx[0]}, 32'h20);
    chk("t3 word1", {16'd0, rx[1]}, 32'h21);
    flush_fifo();

    // 4: single word, FIFO then empty
    clear_mon();
    load(1, 16'h0030);
    en = 1'b1;
    step(8);
    chk("t4 rd count", rd_cnt, 32'd1);
    chk("t4 rd while empty", empty_rd, 32'd0);
    chk("t4 underflow", uf_cnt, 32'd0);
    chk("t4 rd_err", {31'd0, rd_err}, 32'd0);
    chk("t4 pop count", v_cnt, 32'd1);
    chk("t4 word0", {16'd0, rx[0]}, 32'h30);
    en = 1'b0;
    wait_idle("t4 idle");

    // 5: sticky underflow, then reset mid-stream
    uf_force = 1'b1;
    step(1);
    uf_force = 1'b0;
    step(1);
    chk("t5 rd_err set", {31'd0, rd_err}, 32'd1);
    step(3);
    chk("t5 rd_err sticky", {31'd0, rd_err}, 32'd1);
    clear_mon();
    load(8, 16'h0040);
    m_ready = 1'b0;
    en = 1'b1;
    step(6);
    chk("t5 pre valid", {31'd0, m_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 rst m_valid", {31'd0, m_valid}, 32'd0);
    chk("t5 rst busy", {31'd0, busy}, 32'd0);
    chk("t5 rst rd_err", {31'd0, rd_err}, 32'd0);
    chk("t5 rst rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("t5 rst m_data", {16'd0, m_data}, 32'd0);
    en = 1'b0;
    flush_fifo();
    step(1);
    rst_n = 1'b1;
    step(2);

    // 6: five words with one stall
    clear_mon();
    load(5, 16'h0050);
    m_ready = 1'b0;
    en = 1'b1;
    step(5);
    m_ready = 1'b1;
    step(10);
    en = 1'b0;
    wait_idle("t6 idle");
    chk("t6 pop count", v_cnt, 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("t6 word%0d", i), {16'd0, rx[i]}, 32'h50 + 32'(i));
`ifdef FIFO_READ_STATS_EN
    chk("t6 rd_count", {16'd0, rd_count}, 32'd5);
    chk("t6 max_occ", {30'd0, max_occ}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
